lzx_seq_detect: RTL and testbench

Parametrised serial bit-pattern detector, the next generation of our fixed sequence-detector FSM. It is generalised to any pattern length and value, selectable overlapping or non-overlapping detection, an input-qualify enable, and a saturating match counter. It sits on a 1-bit serial data path and produces a registered one-cycle match pulse plus a running match count for downstream status logic.

---
 rtl/lzx_seq_detect.sv | 57 +++++
 tb/tb_lzx_seq_detect.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/lzx_seq_detect.sv
// lzx_seq_detect: parametrised serial bit-pattern detector with a registered
// one-cycle match pulse and a saturating match counter.
module lzx_seq_detect #(
   parameter int               PAT_W   = 3,
   parameter logic [PAT_W-1:0] PATTERN = 3'b101,
   parameter bit               OVERLAP = 1'b1,
   parameter int               CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             ina,
   input  logic             clr_cnt,
   output logic             dataout,
   output logic [CNT_W-1:0] match_cnt
);

   localparam int                FILL_W    = $clog2(PAT_W + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

   logic [PAT_W-1:0]  hist;
   logic [PAT_W-1:0]  nh;
   logic [FILL_W-1:0] fill;
   logic [FILL_W-1:0] nf;
   logic              match;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   // fill gates matching so stale history (reset or post-match) never fires
   always_comb begin
      nh    = (hist << 1) | {{(PAT_W-1){1'b0}}, ina};
      nf    = (fill == FILL_FULL) ? FILL_FULL : fill + 1'b1;
      match = en && (nf == FILL_FULL) && (nh == PATTERN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist      <= '0;
         fill      <= '0;
         dataout   <= 1'b0;
         match_cnt <= '0;
      end else begin
         dataout <= match;
         if (en) begin
            hist <= nh;
            fill <= (match && !OVERLAP) ? '0 : nf;
         end
         if (clr_cnt)
            match_cnt <= '0;
         else if (match)
            match_cnt <= sat_inc(match_cnt);
      end
   end

endmodule

// File: tb/tb_lzx_seq_detect.sv
// Bench for lzx_seq_detect: overlap, non-overlap and 2-bit-counter instances
// driven by one shared directed stream.
module tb_lzx_seq_detect;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       ina;
   logic       clr_cnt;
   logic       ov_out, nv_out, sat_out;
   logic [7:0] ov_cnt, nv_cnt;
   logic [1:0] sat_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   lzx_seq_detect #(.PAT_W(3), .PATTERN(3'b101), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
      .clk(clk), .rst(rst), .en(en), .ina(ina), .clr_cnt(clr_cnt),
      .dataout(ov_out), .match_cnt(ov_cnt));

   lzx_seq_detect #(.PAT_W(3), .PATTERN(3'b101), .OVERLAP(1'b0), .CNT_W(8)) u_nv (
      .clk(clk), .rst(rst), .en(en), .ina(ina), .clr_cnt(clr_cnt),
      .dataout(nv_out), .match_cnt(nv_cnt));

   lzx_seq_detect #(.PAT_W(3), .PATTERN(3'b101), .OVERLAP(1'b1), .CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .en(en), .ina(ina), .clr_cnt(clr_cnt),
      .dataout(sat_out), .match_cnt(sat_cnt));

   typedef struct {
      logic en;
      logic ina;
      logic clr;
      logic ov_out;
      int   ov_cnt;
      logic nv_out;
      int   nv_cnt;
      int   sat_cnt;
   } vec_t;

   vec_t vecs[25];

   function automatic vec_t mk(input logic e, input logic i, input logic c,
                               input logic oo, input int oc,
                               input logic no, input int nc, input int sc);
      vec_t v;
      v.en = e; v.ina = i; v.clr = c;
      v.ov_out = oo; v.ov_cnt = oc;
      v.nv_out = no; v.nv_cnt = nc;
      v.sat_cnt = sc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic oo, input int oc,
                            input logic no, input int nc, input int sc);
      chk({tag, " ov_out"},  32'(ov_out),  32'(oo));
      chk({tag, " ov_cnt"},  32'(ov_cnt),  oc);
      chk({tag, " nv_out"},  32'(nv_out),  32'(no));
      chk({tag, " nv_cnt"},  32'(nv_cnt),  nc);
      chk({tag, " sat_out"}, 32'(sat_out), 32'(oo));
      chk({tag, " sat_cnt"}, 32'(sat_cnt), sc);
   endtask

   task automatic step(input logic e, input logic i, input logic c);
      @(negedge clk);
      en = e; ina = i; clr_cnt = c;
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input int idx);
      step(vecs[idx].en, vecs[idx].ina, vecs[idx].clr);
      check_all($sformatf("vec%0d", idx), vecs[idx].ov_out, vecs[idx].ov_cnt,
                vecs[idx].nv_out, vecs[idx].nv_cnt, vecs[idx].sat_cnt);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; ina = 1'b0; clr_cnt = 1'b0;

      // stream 1,0,1,0,1,1,0,1 from reset
      vecs[0]  = mk(1, 1, 0, 0, 0, 0, 0, 0);
      vecs[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0);
      vecs[2]  = mk(1, 1, 0, 1, 1, 1, 1, 1);
      vecs[3]  = mk(1, 0, 0, 0, 1, 0, 1, 1);
      vecs[4]  = mk(1, 1, 0, 1, 2, 0, 1, 2);
      vecs[5]  = mk(1, 1, 0, 0, 2, 0, 1, 2);
      vecs[6]  = mk(1, 0, 0, 0, 2, 0, 1, 2);
      vecs[7]  = mk(1, 1, 0, 1, 3, 1, 2, 3);
      // enable gaps: 1, (en=0,0) x2, 0, 1
      vecs[8]  = mk(1, 1, 0, 0, 0, 0, 0, 0);
      vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0);
      vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0);
      vecs[11] = mk(1, 0, 0, 0, 0, 0, 0, 0);
      vecs[12] = mk(1, 1, 0, 1, 1, 1, 1, 1);
      // 0,1 repeated: four more overlapping matches, 2-bit counter saturates
      vecs[13] = mk(1, 0, 0, 0, 1, 0, 1, 1);
      vecs[14] = mk(1, 1, 0, 1, 2, 0, 1, 2);
      vecs[15] = mk(1, 0, 0, 0, 2, 0, 1, 2);
      vecs[16] = mk(1, 1, 0, 1, 3, 1, 2, 3);
      vecs[17] = mk(1, 0, 0, 0, 3, 0, 2, 3);
      vecs[18] = mk(1, 1, 0, 1, 4, 0, 2, 3);
      vecs[19] = mk(1, 0, 0, 0, 4, 0, 2, 3);
      vecs[20] = mk(1, 1, 0, 1, 5, 1, 3, 3);
      // clear on the same edge as a match; fill is untouched by clr_cnt
      vecs[21] = mk(1, 0, 0, 0, 5, 0, 3, 3);
      vecs[22] = mk(1, 1, 1, 1, 0, 0, 0, 0);
      vecs[23] = mk(1, 0, 0, 0, 0, 0, 0, 0);
      vecs[24] = mk(1, 1, 0, 1, 1, 1, 1, 1);

      #1;
      check_all("reset", 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) run_vec(i);

      // asynchronous reset mid-cycle while dataout and counts are nonzero
      #2;
      rst = 1'b1;
      #1;
      check_all("async_rst", 0, 0, 0, 0, 0);
      en = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      for (int i = 8; i < 25; i++) run_vec(i);

      // reset mid-sequence: 1,0, reset, then 1 alone must not match
      step(1, 1, 0);
      check_all("mid_a", 0, 1, 0, 1, 1);
      step(1, 0, 0);
      check_all("mid_b", 0, 1, 0, 1, 1);
      #2;
      rst = 1'b1;
      ina = 1'b1;
      #1;
      check_all("mid_rst", 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      check_all("mid_rst_held", 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      en  = 1'b0;
      step(1, 1, 0);
      check_all("post_rst_1", 0, 0, 0, 0, 0);
      step(1, 0, 0);
      check_all("post_rst_0", 0, 0, 0, 0, 0);
      step(1, 1, 0);
      check_all("post_rst_match", 1, 1, 1, 1, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
